// File: rtl/sd_data_checker.sv
// rtl/sd_data_checker.sv - SD sector write/read-back self-test with pass/fail flags
module sd_data_checker #(
    parameter logic [31:0] SEC_ADDR = 32'd2000,
    parameter logic [8:0]  WORDS    = 9'd256,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    input  logic        rd_busy,
    input  logic        rd_val_en,
    input  logic [15:0] rd_val_data,
    output logic        error_flag,
    output logic        test_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_START, S_WR_WAIT, S_RD_START, S_RD_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_init_meta, r_init_s;
    logic        r_seen_busy;
    logic [23:0] r_to_cnt;
    logic [9:0]  r_rd_cnt, r_ok_cnt;
    logic        r_wr_start_en, r_rd_start_en, r_error_flag, r_test_done;
    logic [15:0] r_wr_data;
    logic        w_in_wait, w_abort, w_timeout, w_busy;
    logic        w_error_next, w_done_next;

    assign w_in_wait = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    assign w_abort   = !r_init_s && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout = w_in_wait && !r_seen_busy && (r_to_cnt == TIMEOUT - 24'd1);
    assign w_busy    = (r_state == S_WR_WAIT) ? wr_busy : rd_busy;

    always_comb begin
        w_state_next = r_state;
        w_error_next = r_error_flag;
        w_done_next  = r_test_done;
        if (w_abort || w_timeout) begin
            w_state_next = S_DONE;
            w_error_next = 1'b1;
            w_done_next  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:     if (r_init_s) w_state_next = S_WR_START;
                S_WR_START: w_state_next = S_WR_WAIT;
                S_WR_WAIT:  if (r_seen_busy && !wr_busy) w_state_next = S_RD_START;
                S_RD_START: w_state_next = S_RD_WAIT;
                S_RD_WAIT:  if (r_seen_busy && !rd_busy) w_state_next = S_CHECK;
                S_CHECK: begin
                    w_state_next = S_DONE;
                    w_error_next = r_error_flag
                                 | (r_ok_cnt != {1'b0, WORDS})
                                 | (r_rd_cnt != {1'b0, WORDS});
                    w_done_next  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_init_meta   <= 1'b0;
            r_init_s      <= 1'b0;
            r_wr_start_en <= 1'b0;
            r_rd_start_en <= 1'b0;
            r_error_flag  <= 1'b0;
            r_test_done   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_init_meta   <= sd_init_done;
            r_init_s      <= r_init_meta;
            r_wr_start_en <= (w_state_next == S_WR_START);
            r_rd_start_en <= (w_state_next == S_RD_START);
            r_error_flag  <= w_error_next;
            r_test_done   <= w_done_next;
        end
    end

    // Busy tracking and timeout restart each time a transfer is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen_busy <= 1'b0;
            r_to_cnt    <= 24'd0;
            r_wr_data   <= 16'd0;
            r_rd_cnt    <= 10'd0;
            r_ok_cnt    <= 10'd0;
        end else begin
            if (r_state == S_WR_START || r_state == S_RD_START) begin
                r_seen_busy <= 1'b0;
                r_to_cnt    <= 24'd0;
            end else if (w_in_wait) begin
                if (w_busy) r_seen_busy <= 1'b1;
                if (!r_seen_busy) r_to_cnt <= r_to_cnt + 24'd1;
            end

            if (r_state == S_WR_START)
                r_wr_data <= 16'd0;
            else if (r_state == S_WR_WAIT && wr_req)
                r_wr_data <= r_wr_data + 16'd1;

            if (r_state == S_RD_START) begin
                r_rd_cnt <= 10'd0;
                r_ok_cnt <= 10'd0;
            end else if (r_state == S_RD_WAIT && rd_val_en) begin
                if (r_rd_cnt != 10'h3FF) r_rd_cnt <= r_rd_cnt + 10'd1;
                if (rd_val_data == {6'd0, r_rd_cnt} && r_ok_cnt != 10'h3FF)
                    r_ok_cnt <= r_ok_cnt + 10'd1;
            end
        end
    end

    assign wr_start_en = r_wr_start_en;
    assign rd_start_en = r_rd_start_en;
    assign wr_data     = r_wr_data;
    assign error_flag  = r_error_flag;
    assign test_done   = r_test_done;
    assign wr_sec_addr = SEC_ADDR;
    assign rd_sec_addr = SEC_ADDR;

endmodule

// File: tb/tb_sd_data_checker.sv
// tb/tb_sd_data_checker.sv - directed/randomized self-checking bench for sd_data_checker
module tb_sd_data_checker;

    logic        clk = 1'b0;
    logic        rst_n, sd_init_done;
    logic        wr_busy, wr_req, rd_busy, rd_val_en;
    logic [15:0] rd_val_data;
    logic        wr_start_en, rd_start_en, error_flag, test_done;
    logic [31:0] wr_sec_addr, rd_sec_addr;
    logic [15:0] wr_data;

    always #5 clk = ~clk;

    sd_data_checker #(
        .SEC_ADDR(32'd2000),
        .WORDS   (9'd256),
        .TIMEOUT (24'd100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sd_init_done(sd_init_done),
        .wr_start_en (wr_start_en),
        .wr_sec_addr (wr_sec_addr),
        .wr_busy     (wr_busy),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .rd_start_en (rd_start_en),
        .rd_sec_addr (rd_sec_addr),
        .rd_busy     (rd_busy),
        .rd_val_en   (rd_val_en),
        .rd_val_data (rd_val_data),
        .error_flag  (error_flag),
        .test_done   (test_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic [15:0] wr_seen[$];
    logic [15:0] rd_sent[$];

    always @(negedge clk) begin
        if (wr_start_en === 1'b1 && !prev_wr) wr_pulses++;
        if (rd_start_en === 1'b1 && !prev_rd) rd_pulses++;
        prev_wr = (wr_start_en === 1'b1);
        prev_rd = (rd_start_en === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; sd_init_done = 1'b0;
        wr_busy = 1'b0; wr_req = 1'b0;
        rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = 16'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_wr_start", tag), {31'd0, wr_start_en}, 32'd0);
        check($sformatf("%s_rd_start", tag), {31'd0, rd_start_en}, 32'd0);
        check($sformatf("%s_wr_data", tag), {16'd0, wr_data}, 32'd0);
        check($sformatf("%s_error", tag), {31'd0, error_flag}, 32'd0);
        check($sformatf("%s_done", tag), {31'd0, test_done}, 32'd0);
        check($sformatf("%s_wr_addr", tag), wr_sec_addr, 32'd2000);
        check($sformatf("%s_rd_addr", tag), rd_sec_addr, 32'd2000);
    endtask

    task automatic wait_wr_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (wr_start_en === 1'b1);
        end
        check($sformatf("%s_wr_start_seen", tag), {31'd0, seen}, 32'd1);
    endtask

    // Controller write side: busy for 600 cycles, 256 requests scattered inside.
    task automatic do_write(input string tag);
        int left;
        int bad;
        wr_seen.delete();
        repeat (3) tick();
        wr_busy = 1'b1;
        left = 256;
        for (int c = 0; c < 600; c++) begin
            wr_req = (left > 0) && ((c % 2 == 0) || ($urandom_range(0, 3) == 0));
            if (wr_req) begin
                wr_seen.push_back(wr_data);
                left--;
            end
            tick();
        end
        wr_req = 1'b0;
        wr_busy = 1'b0;
        bad = 0;
        foreach (wr_seen[i]) if (wr_seen[i] !== 16'(i)) bad++;
        check($sformatf("%s_wr_count", tag), wr_seen.size(), 32'd256);
        check($sformatf("%s_wr_pattern_bad", tag), bad, 32'd0);
        tick();
        check($sformatf("%s_rd_start_hi", tag), {31'd0, rd_start_en}, 32'd1);
        tick();
        check($sformatf("%s_rd_start_lo", tag), {31'd0, rd_start_en}, 32'd0);
    endtask

    // Controller read side: echoes written words, optional corruption/short/fall-cycle word.
    task automatic do_read(input string tag, input int n_words, input int bad_idx, input bit last_on_fall);
        int sent;
        int limit;
        bit exp_err;
        bit got;
        rd_sent.delete();
        sent = 0;
        limit = last_on_fall ? n_words - 1 : n_words;
        repeat (2) tick();
        rd_busy = 1'b1;
        for (int c = 0; c < 601; c++) begin
            if (c == 600) begin
                rd_busy = 1'b0;
                rd_val_en = (sent < n_words);
            end else begin
                rd_val_en = (sent < limit) && ((c % 2 == 0) || ($urandom_range(0, 3) == 0));
            end
            if (rd_val_en) begin
                rd_val_data = (sent == bad_idx) ? 16'h1234 :
                              (sent < wr_seen.size()) ? wr_seen[sent] : 16'(sent);
                rd_sent.push_back(rd_val_data);
                sent++;
            end
            tick();
        end
        rd_val_en = 1'b0;
        exp_err = (rd_sent.size() != 256);
        foreach (rd_sent[i]) if (rd_sent[i] !== 16'(i)) exp_err = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (test_done === 1'b1) got = 1'b1;
            else tick();
        end
        check($sformatf("%s_done", tag), {31'd0, test_done}, 32'd1);
        check($sformatf("%s_error", tag), {31'd0, error_flag}, {31'd0, exp_err});
    endtask

    initial begin
        int w0;
        int r0;
        bit got;

        // Reset values, including constant sector addresses while held in reset
        rst_n = 1'b0; sd_init_done = 1'b0;
        wr_busy = 1'b0; wr_req = 1'b0;
        rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = 16'd0;
        repeat (2) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_start", {31'd0, wr_start_en}, 32'd0);

        // Clean pass with exact start latency
        w0 = wr_pulses; r0 = rd_pulses;
        sd_init_done = 1'b1;
        tick(); check("lat_e0", {31'd0, wr_start_en}, 32'd0);
        tick(); check("lat_e1", {31'd0, wr_start_en}, 32'd0);
        tick(); check("lat_e2", {31'd0, wr_start_en}, 32'd1);
        tick(); check("lat_e3", {31'd0, wr_start_en}, 32'd0);
        do_write("clean");
        do_read("clean", 256, -1, 1'b0);
        repeat (20) tick();
        check("clean_done_sticky", {31'd0, test_done}, 32'd1);
        check("clean_wr_pulses", wr_pulses - w0, 32'd1);
        check("clean_rd_pulses", rd_pulses - r0, 32'd1);

        // Single corruption on word 17
        apply_reset();
        sd_init_done = 1'b1;
        wait_wr_start("corrupt");
        do_write("corrupt");
        do_read("corrupt", 256, 17, 1'b0);

        // Short read of 255 words
        apply_reset();
        sd_init_done = 1'b1;
        wait_wr_start("short");
        do_write("short");
        do_read("short", 255, -1, 1'b0);

        // Last word arrives in the rd_busy fall cycle
        apply_reset();
        sd_init_done = 1'b1;
        wait_wr_start("fall");
        do_write("fall");
        do_read("fall", 256, -1, 1'b1);

        // Timeout: wr_busy never rises
        apply_reset();
        r0 = rd_pulses;
        sd_init_done = 1'b1;
        wait_wr_start("tmo");
        repeat (90) tick();
        check("tmo_not_early", {31'd0, test_done}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = (test_done === 1'b1);
        end
        check("tmo_done", {31'd0, test_done}, 32'd1);
        check("tmo_error", {31'd0, error_flag}, 32'd1);
        repeat (10) tick();
        check("tmo_no_rd_start", rd_pulses - r0, 32'd0);

        // Abort: init drops during the read phase
        apply_reset();
        sd_init_done = 1'b1;
        wait_wr_start("abort");
        do_write("abort");
        repeat (2) tick();
        rd_busy = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rd_val_en = (c % 2 == 0);
            rd_val_data = 16'(c / 2);
            tick();
        end
        rd_val_en = 1'b0;
        sd_init_done = 1'b0;
        repeat (3) tick();
        check("abort_done", {31'd0, test_done}, 32'd1);
        check("abort_error", {31'd0, error_flag}, 32'd1);
        rd_busy = 1'b0;

        // Mid-test reset during the write phase, then a full clean rerun
        apply_reset();
        sd_init_done = 1'b1;
        wait_wr_start("midrst");
        repeat (3) tick();
        wr_busy = 1'b1;
        wr_req = 1'b1;
        repeat (40) tick();
        check("midrst_wr_data_pre", {16'd0, wr_data}, 32'd40);
        rst_n = 1'b0;
        wr_busy = 1'b0;
        wr_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        w0 = wr_pulses; r0 = rd_pulses;
        rst_n = 1'b1;
        tick(); check("midrst_lat_e0", {31'd0, wr_start_en}, 32'd0);
        tick(); check("midrst_lat_e1", {31'd0, wr_start_en}, 32'd0);
        tick(); check("midrst_lat_e2", {31'd0, wr_start_en}, 32'd1);
        do_write("midrst");
        do_read("midrst", 256, -1, 1'b0);
        repeat (5) tick();
        check("midrst_wr_pulses", wr_pulses - w0, 32'd1);
        check("midrst_rd_pulses", rd_pulses - r0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
